// File: rtl/clockworks_pkg.sv
// Shared constants and helpers for the clockworks clock/reset generator.
// Build option: CLOCKWORKS_RESET_STRETCH_EN selects the stretched reset release.
package clockworks_pkg;

  // Default clock division exponent: out_clk period is 2^SLOW clk cycles.
  localparam int unsigned CLOCKWORKS_SLOW_DEFAULT         = 10;
  // Default reset stretch, counted in out_clk cycles.
  localparam int unsigned CLOCKWORKS_RESET_CYCLES_DEFAULT = 15;
  // Largest supported division exponent.
  localparam int unsigned CLOCKWORKS_SLOW_MAX             = 24;
  // Largest supported stretch length; sets the stretch counter width.
  localparam int unsigned CLOCKWORKS_RESET_CYCLES_MAX     = 255;
  localparam int unsigned CLOCKWORKS_STRETCH_W            = 8;

  typedef logic [CLOCKWORKS_STRETCH_W-1:0] stretch_cnt_t;

  // Reload value for the stretch counter. Out-of-range requests are pulled back into
  // 1..255 so a bad parameter never yields a zero-length (no-op) stretch or a silent wrap.
  function automatic stretch_cnt_t stretch_load(input int unsigned cycles);
    stretch_cnt_t load;
    if (cycles == 0) begin
      load = stretch_cnt_t'(1);
    end else if (cycles > CLOCKWORKS_RESET_CYCLES_MAX) begin
      load = stretch_cnt_t'(CLOCKWORKS_RESET_CYCLES_MAX);
    end else begin
      load = stretch_cnt_t'(cycles);
    end
    return load;
  endfunction

endpackage

// File: rtl/clockworks_sync.sv
// Two-flop synchronizer bringing the board reset into the out_clk domain.
// Both flops power up at INIT so the block starts in a known (asserted) state.
module clockworks_sync
  import clockworks_pkg::*;
#(
  parameter logic INIT = 1'b1
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q = INIT;
  logic sync_q = INIT;

  // Shift the asynchronous input through two stages to settle metastability.
  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clockworks.sv
// Clock divider and reset conditioner for a downstream SoC.
// out_clk = clk / 2^SLOW (or clk itself when SLOW = 0); out_reset is a synchronous,
// active-high reset in the out_clk domain that is asserted at power-up.
// Build option: define CLOCKWORKS_RESET_STRETCH_EN to hold out_reset for RESET_CYCLES
// out_clk cycles after the synchronized reset releases; otherwise out_reset is the
// synchronizer output registered once more.
module clockworks
  import clockworks_pkg::*;
#(
  parameter int unsigned SLOW         = CLOCKWORKS_SLOW_DEFAULT,
  parameter int unsigned RESET_CYCLES = CLOCKWORKS_RESET_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic out_clk,
  output logic out_reset
);

  // ---------------------------------------------------------------------------
  // Clock divider. Deliberately has no reset: out_clk must keep running while
  // reset is held so the out_clk-domain logic can actually see out_reset.
  // ---------------------------------------------------------------------------
  if (SLOW == 0) begin : gen_direct
    assign out_clk = clk;
  end else begin : gen_div
    logic [SLOW-1:0] div_q = '0;
    logic [SLOW-1:0] div_d;

    // Free-running increment; natural wrap keeps the MSB a clean 50% square wave.
    always_comb begin
      div_d = div_q + SLOW'(1);
    end

    // Divider state register.
    always_ff @(posedge clk) begin
      div_q <= div_d;
    end

    assign out_clk = div_q[SLOW-1];
  end

  // ---------------------------------------------------------------------------
  // Reset synchronizer into the out_clk domain.
  // ---------------------------------------------------------------------------
  logic rst_sync;

  clockworks_sync #(
    .INIT (1'b1)
  ) u_sync (
    .clk_i (out_clk),
    .d_i   (reset),
    .q_o   (rst_sync)
  );

`ifdef CLOCKWORKS_RESET_STRETCH_EN
  // ---------------------------------------------------------------------------
  // Stretched release: hold out_reset until the counter drains after release.
  // ---------------------------------------------------------------------------
  localparam stretch_cnt_t ResetLoad = stretch_load(RESET_CYCLES);

  stretch_cnt_t stretch_q = ResetLoad;
  stretch_cnt_t stretch_d;
  logic         out_reset_q = 1'b1;
  logic         out_reset_d;

  // Reload while reset is seen, otherwise count down and drop out_reset on reaching 0.
  always_comb begin
    stretch_d   = stretch_q;
    out_reset_d = out_reset_q;
    if (rst_sync) begin
      stretch_d   = ResetLoad;
      out_reset_d = 1'b1;
    end else if (stretch_q != '0) begin
      stretch_d   = stretch_q - stretch_cnt_t'(1);
      // Deassert on the same edge the counter lands on zero.
      out_reset_d = (stretch_q != stretch_cnt_t'(1));
    end else begin
      out_reset_d = 1'b0;
    end
  end

  // Stretch counter and out_reset registers, clocked only by out_clk.
  always_ff @(posedge out_clk) begin
    stretch_q   <= stretch_d;
    out_reset_q <= out_reset_d;
  end
`else
  // ---------------------------------------------------------------------------
  // Plain release: one register stage after the synchronizer, no counter.
  // ---------------------------------------------------------------------------
  logic out_reset_q = 1'b1;

  // Retime the synchronized reset so out_reset only changes on out_clk rising edges.
  always_ff @(posedge out_clk) begin
    out_reset_q <= rst_sync;
  end
`endif

  assign out_reset = out_reset_q;

endmodule

// File: tb/tb_clockworks.sv
// Self-checking bench for clockworks: divider timing, power-up reset, held reset,
// mid-stretch re-assertion, SLOW=0 pass-through and short reset pulses.
// Three instances share one clk: SLOW=10 (slow), SLOW=2 (fast), SLOW=0 (zero).
module tb_clockworks;

  localparam int unsigned RC = 15;
`ifdef CLOCKWORKS_RESET_STRETCH_EN
  localparam int RelLat  = RC + 2;
  localparam bit Stretch = 1'b1;
`else
  localparam int RelLat  = 3;
  localparam bit Stretch = 1'b0;
`endif
  localparam int AsrtLat = 3;
  localparam int Bound   = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r_slow = 1'b0;
  logic r_fast = 1'b0;
  logic r_zero = 1'b0;
  logic slow_clk, slow_rst, fast_clk, fast_rst, zero_clk, zero_rst;

  clockworks #(.SLOW(10), .RESET_CYCLES(RC)) u_slow (
    .clk(clk), .reset(r_slow), .out_clk(slow_clk), .out_reset(slow_rst));
  clockworks #(.SLOW(2), .RESET_CYCLES(RC)) u_fast (
    .clk(clk), .reset(r_fast), .out_clk(fast_clk), .out_reset(fast_rst));
  clockworks #(.SLOW(0), .RESET_CYCLES(RC)) u_zero (
    .clk(clk), .reset(r_zero), .out_clk(zero_clk), .out_reset(zero_rst));

  int cyc = 0;
  int slow_edges = 0;
  int fast_edges = 0;
  int zero_edges = 0;
  always @(posedge clk)      cyc        <= cyc + 1;
  always @(posedge slow_clk) slow_edges <= slow_edges + 1;
  always @(posedge fast_clk) fast_edges <= fast_edges + 1;
  always @(posedge zero_clk) zero_edges <= zero_edges + 1;

  // Power-up release observers: remember the out_clk edge index of the first fall.
  bit slow_fell = 1'b0, fast_fell = 1'b0, zero_fell = 1'b0;
  int slow_fall_edge = 0, fast_fall_edge = 0, zero_fall_edge = 0;
  always @(negedge clk) begin
    if (!slow_fell && slow_rst === 1'b0) begin
      slow_fell      <= 1'b1;
      slow_fall_edge <= slow_edges;
    end
    if (!fast_fell && fast_rst === 1'b0) begin
      fast_fell      <= 1'b1;
      fast_fall_edge <= fast_edges;
    end
    if (!zero_fell && zero_rst === 1'b0) begin
      zero_fell      <= 1'b1;
      zero_fall_edge <= zero_edges;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  function automatic int edges_of(input int id);
    case (id)
      0:       return slow_edges;
      1:       return fast_edges;
      default: return zero_edges;
    endcase
  endfunction

  function automatic logic rst_of(input int id);
    case (id)
      0:       return slow_rst;
      1:       return fast_rst;
      default: return zero_rst;
    endcase
  endfunction

  // Wait (bounded) for out_reset of instance id to reach val; report out_clk edges taken.
  task automatic wait_level(input int id, input logic val, output int delta, output bit tmo);
    int base;
    int n;
    base = edges_of(id);
    n = 0;
    while (rst_of(id) !== val && n < Bound) begin
      @(negedge clk);
      n++;
    end
    tmo   = (rst_of(id) !== val);
    delta = edges_of(id) - base;
  endtask

  // Wait (bounded) for n more out_clk rising edges of instance id.
  task automatic wait_edges(input int id, input int n, output bit tmo);
    int target;
    int k;
    target = edges_of(id) + n;
    k = 0;
    while (edges_of(id) < target && k < Bound) begin
      @(negedge clk);
      k++;
    end
    tmo = (edges_of(id) < target);
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (slow_rst !== 1'b1) begin
      miscompares++; $display("FAIL reset_slow_out_reset: got %b, want 1", slow_rst);
    end
    vectors++;
    if (fast_rst !== 1'b1) begin
      miscompares++; $display("FAIL reset_fast_out_reset: got %b, want 1", fast_rst);
    end
    vectors++;
    if (zero_rst !== 1'b1) begin
      miscompares++; $display("FAIL reset_zero_out_reset: got %b, want 1", zero_rst);
    end
    vectors++;
    if (slow_clk !== 1'b0) begin
      miscompares++; $display("FAIL reset_slow_out_clk: got %b, want 0", slow_clk);
    end
    vectors++;
    if (fast_clk !== 1'b0) begin
      miscompares++; $display("FAIL reset_fast_out_clk: got %b, want 0", fast_clk);
    end
  endtask

  // SLOW=10: edges alternate rise/fall every 512 cycles, first rise at cycle 512.
  task automatic test_clock_divider;
    logic prev;
    int   e;
    prev = slow_clk;
    for (int i = 0; i < 8; i++) exp_q.push_back((512 * (i + 1)) * 2 + ((i % 2 == 0) ? 1 : 0));
    repeat (4096) begin
      @(negedge clk);
      if (slow_clk !== prev) begin
        prev = slow_clk;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL divider_extra_edge: got edge to %b at cycle %0d, want none", slow_clk,
                   cyc);
        end else begin
          e = exp_q.pop_front();
          if ((cyc * 2 + int'(slow_clk)) !== e) begin
            miscompares++;
            $display("FAIL divider_edge: got %b at cycle %0d, want %0d at cycle %0d", slow_clk,
                     cyc, e % 2, e / 2);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL divider_missing_edges: got %0d edges, want 8", 8 - exp_q.size());
    end
    exp_q.delete();
  endtask

  // All instances power up in reset and release without reset ever being pressed.
  task automatic test_power_up;
    int n;
    int e;
    bit tmo;
    for (int i = 0; i < 3; i++) exp_q.push_back(RelLat);
    n = 0;
    while (!(slow_fell && fast_fell && zero_fell) && n < Bound) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    vectors++;
    if (!slow_fell || slow_fall_edge !== e) begin
      miscompares++;
      $display("FAIL power_up_slow: got fall at edge %0d (fell=%0b), want %0d", slow_fall_edge,
               slow_fell, e);
    end
    e = exp_q.pop_front();
    vectors++;
    if (!fast_fell || fast_fall_edge !== e) begin
      miscompares++;
      $display("FAIL power_up_fast: got fall at edge %0d (fell=%0b), want %0d", fast_fall_edge,
               fast_fell, e);
    end
    e = exp_q.pop_front();
    vectors++;
    if (!zero_fell || zero_fall_edge !== e) begin
      miscompares++;
      $display("FAIL power_up_zero: got fall at edge %0d (fell=%0b), want %0d", zero_fall_edge,
               zero_fell, e);
    end
    wait_edges(0, 2, tmo);
    vectors++;
    if (tmo || slow_rst !== 1'b0 || fast_rst !== 1'b0 || zero_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL power_up_stays_low: got %b%b%b tmo=%0b, want 000", slow_rst, fast_rst,
               zero_rst, tmo);
    end
  endtask

  // SLOW=0: out_clk follows clk with no cycle of offset.
  task automatic test_zero_track;
    repeat (8) begin
      @(posedge clk);
      #1;
      vectors++;
      if (zero_clk !== 1'b1) begin
        miscompares++; $display("FAIL zero_track_high: got %b, want 1", zero_clk);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (zero_clk !== 1'b0) begin
        miscompares++; $display("FAIL zero_track_low: got %b, want 0", zero_clk);
      end
    end
  endtask

  // Reset held 3000 clk cycles: out_reset high throughout, out_clk keeps running.
  task automatic test_release_held;
    int delta;
    int e;
    bit tmo;
    int start;
    int bad_rst;
    int bad_clk;
    @(negedge clk);
    r_fast = 1'b1;
    start  = cyc;
    exp_q.push_back(AsrtLat);
    wait_level(1, 1'b1, delta, tmo);
    e = exp_q.pop_front();
    vectors++;
    if (tmo || delta !== e) begin
      miscompares++;
      $display("FAIL held_assert_latency: got %0d edges tmo=%0b, want %0d", delta, tmo, e);
    end
    bad_rst = 0;
    bad_clk = 0;
    while (cyc - start < 3000) begin
      @(negedge clk);
      if (fast_rst !== 1'b1) bad_rst++;
      if (fast_clk !== cyc[1]) bad_clk++;
    end
    vectors++;
    if (bad_rst != 0) begin
      miscompares++;
      $display("FAIL held_out_reset: got %0d low samples, want 0", bad_rst);
    end
    vectors++;
    if (bad_clk != 0) begin
      miscompares++;
      $display("FAIL held_out_clk_running: got %0d wrong samples, want 0", bad_clk);
    end
    r_fast = 1'b0;
    exp_q.push_back(RelLat);
    wait_level(1, 1'b0, delta, tmo);
    e = exp_q.pop_front();
    vectors++;
    if (tmo || delta !== e) begin
      miscompares++;
      $display("FAIL held_release_latency: got %0d edges tmo=%0b, want %0d", delta, tmo, e);
    end
  endtask

  // Re-assert 5 stretch cycles into a release; the full count restarts afterwards.
  task automatic test_reassert;
    int delta;
    int e;
    bit tmo;
    @(negedge clk);
    r_fast = 1'b1;
    exp_q.push_back(AsrtLat);
    wait_level(1, 1'b1, delta, tmo);
    e = exp_q.pop_front();
    vectors++;
    if (tmo || delta !== e) begin
      miscompares++;
      $display("FAIL reassert_first_assert: got %0d edges tmo=%0b, want %0d", delta, tmo, e);
    end
    wait_edges(1, 2, tmo);
    r_fast = 1'b0;
    wait_edges(1, 7, tmo);
    vectors++;
    if (tmo || fast_rst !== Stretch) begin
      miscompares++;
      $display("FAIL reassert_mid_stretch: got %b tmo=%0b, want %b", fast_rst, tmo, Stretch);
    end
    r_fast = 1'b1;
    wait_edges(1, 4, tmo);
    r_fast = 1'b0;
    exp_q.push_back(RelLat);
    wait_level(1, 1'b0, delta, tmo);
    e = exp_q.pop_front();
    vectors++;
    if (tmo || delta !== e) begin
      miscompares++;
      $display("FAIL reassert_release_latency: got %0d edges tmo=%0b, want %0d", delta, tmo, e);
    end
  endtask

  // SLOW=0 release latency, counted in clk edges.
  task automatic test_zero_release;
    int delta;
    int e;
    bit tmo;
    @(negedge clk);
    r_zero = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (zero_rst !== 1'b1) begin
      miscompares++; $display("FAIL zero_asserted: got %b, want 1", zero_rst);
    end
    r_zero = 1'b0;
    exp_q.push_back(RelLat);
    wait_level(2, 1'b0, delta, tmo);
    e = exp_q.pop_front();
    vectors++;
    if (tmo || delta !== e) begin
      miscompares++;
      $display("FAIL zero_release_latency: got %0d edges tmo=%0b, want %0d", delta, tmo, e);
    end
  endtask

  // One-cycle pulse away from any out_clk rise: never sampled, outputs stay clean.
  task automatic test_short_pulse;
    int n;
    int bad_rst;
    int bad_clk;
    n = 0;
    @(negedge clk);
    while (cyc % 1024 != 100 && n < 2048) begin
      @(negedge clk);
      n++;
    end
    r_slow = 1'b1;
    @(negedge clk);
    r_slow = 1'b0;
    bad_rst = 0;
    bad_clk = 0;
    repeat (3000) begin
      @(negedge clk);
      if (slow_rst !== 1'b0) bad_rst++;
      if (slow_clk !== cyc[9]) bad_clk++;
    end
    vectors++;
    if (bad_rst != 0) begin
      miscompares++;
      $display("FAIL short_pulse_out_reset: got %0d non-zero samples, want 0", bad_rst);
    end
    vectors++;
    if (bad_clk != 0) begin
      miscompares++;
      $display("FAIL short_pulse_out_clk: got %0d wrong samples, want 0", bad_clk);
    end
  endtask

  initial begin
    test_reset();
    test_clock_divider();
    test_power_up();
    test_zero_track();
    test_release_held();
    test_reassert();
    test_zero_release();
    test_short_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clockworks.md
CLOCKWORKS -- requirements
Module: clockworks

Interface
REQ-001 Parameter SLOW, default 10: clock division exponent; legal range 0..24; out_clk period = 2^SLOW clk cycles.
REQ-002 Parameter RESET_CYCLES, default 15: reset stretch length in out_clk cycles; legal range 1..255.
REQ-003 clk  input  1  board clock; all logic in this block is clocked by clk or out_clk.
REQ-004 reset  input  1  reset button; reset reset, synchronous, active-high; clock clk.
REQ-005 out_clk  output  1  divided system clock for the downstream SoC.
REQ-006 out_reset  output  1  active-high synchronous reset for logic clocked by out_clk.

Function
REQ-007 For SLOW=0, out_clk SHALL be a direct combinational copy of clk, with no divider register.
REQ-008 For SLOW>0, the block SHALL hold a free-running SLOW-bit up-counter on clk, with out_clk = counter[SLOW-1].
- 50% duty cycle.
- Period 2^SLOW clk cycles; for SLOW=10, 512 high / 512 low.
REQ-009 The counter SHALL wrap from all-ones to zero with no glitch or skipped edge on out_clk.
REQ-010 The counter SHALL NOT be cleared by reset, so out_clk keeps toggling and downstream logic samples out_reset.
REQ-011 The counter SHALL initialise to 0 at power-up, so the first out_clk rising edge occurs 2^(SLOW-1) clk cycles after start.
REQ-012 reset SHALL be sampled into the out_clk domain through a two-flop synchronizer clocked by out_clk rising edges.
REQ-013 out_reset SHALL be a register clocked by out_clk, changing only on out_clk rising edges.
REQ-014 While the synchronized reset is high, out_reset SHALL be 1 and the stretch counter SHALL reload to RESET_CYCLES.
REQ-015 Release, with the stretch feature compiled in:
- After the synchronized reset falls, the stretch counter decrements once per out_clk rising edge.
- out_reset deasserts on the edge the counter reaches 0.
REQ-016 A reset pulse shorter than one out_clk period SHALL NOT be guaranteed to take effect.
REQ-017 A pulse held at least 2 out_clk periods SHALL always assert out_reset.
REQ-018 Reset re-asserted mid-stretch SHALL reload the stretch counter and restart the full RESET_CYCLES count after release.

Reset
REQ-019 At power-up, out_reset SHALL initialise to 1, the synchronizer flops to 1 and the stretch counter to RESET_CYCLES, so a power-on reset occurs without pressing reset.
REQ-020 Only the synchronizer, stretch counter and out_reset SHALL respond to reset; the divider counter SHALL be exempt.

Configuration
REQ-021 Macro CLOCKWORKS_RESET_STRETCH_EN SHALL select the reset release behaviour:
- Defined: out_reset stays asserted for RESET_CYCLES out_clk cycles after release (REQ-015).
- Undefined: out_reset equals the synchronizer output delayed by one out_clk register stage, and no stretch counter is built.

Structure
REQ-022 A shared package clockworks_pkg SHALL hold the constants:
- CLOCKWORKS_SLOW_DEFAULT = 10.
- CLOCKWORKS_RESET_CYCLES_DEFAULT = 15.
- CLOCKWORKS_SLOW_MAX = 24.
REQ-023 The two-flop synchronizer SHALL be a sub-module named clockworks_sync with a parameterised reset/init value.
REQ-024 clockworks SHALL contain no other sub-modules.

Verification
REQ-025 SLOW=10, free run for 4096 clk cycles -> out_clk toggles every 512 clk cycles; 4 full periods observed; first rise at clk cycle 512.
REQ-026 Power-up with reset=0, stretch enabled -> out_reset=1 until the 15th+2 out_clk rising edge, then 0 and stays 0.
REQ-027 reset=1 held 3000 clk cycles then 0 -> out_reset=1 throughout; out_reset falls exactly RESET_CYCLES+2 out_clk edges after release; out_clk never pauses.
REQ-028 reset re-asserted after 5 stretch cycles -> count restarts; out_reset stays 1 for the full 15 cycles after the second release.
REQ-029 SLOW=0 -> out_clk tracks clk with zero cycle offset; with CLOCKWORKS_RESET_STRETCH_EN undefined, out_reset falls 3 clk edges after reset falls.
REQ-030 reset pulse of 1 clk cycle at SLOW=10 -> out_reset may stay 0, with no X on any output.
